// File: rtl/leak_coef_pkg.sv
// Shared constants and types for the 0.9999 leak pair: the forward
// multiply-by-0.9999 block and its inverse, bit64_divide_0dot9999.
//
// Contents:
//   LEAK_DATA_W    default signed operand/result width
//   LEAK_COEF_NUM  scaling numerator   (10000)
//   LEAK_COEF_DEN  scaling denominator (9999, i.e. 0.9999 * LEAK_COEF_NUM)
//   DIVIDEND_W     width of the unsigned |x| * COEF_NUM dividend
//   ITER_N         number of radix-2 division steps
//   leak_state_e   handshake/iteration FSM states
package leak_coef_pkg;

  localparam int LEAK_DATA_W   = 64;
  localparam int LEAK_COEF_NUM = 10000;
  localparam int LEAK_COEF_DEN = 9999;

  // |x| <= 2^63 and COEF_NUM < 2^14, so the product fits in 77 bits;
  // 80 leaves headroom and keeps the step count a round number.
  localparam int DIVIDEND_W = 80;
  localparam int ITER_N     = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } leak_state_e;

endpackage

// File: rtl/udiv_serial.sv
// Unsigned restoring shift-subtract divider, one quotient bit per step,
// MSB first.
//
// Ports:
//   clk, rst_n  clock; synchronous active-low reset
//   start       load dividend, clear remainder/quotient, arm ITER steps
//   step        perform one division step this cycle (while busy)
//   dividend    N_W-bit unsigned dividend, sampled on start
//   divisor     D_W-bit unsigned divisor, must stay constant while busy
//   busy        steps remain to be performed
//   last        the step performed this cycle (if stepped) is the final one
//   quotient    N_W-bit quotient, complete once busy falls
module udiv_serial #(
  parameter int N_W  = 80,
  parameter int D_W  = 14,
  parameter int ITER = N_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           last,
  output logic [N_W-1:0] quotient
);

  localparam int CNT_W = $clog2(ITER);

  logic [N_W-1:0]   dvd_q;
  logic [D_W-1:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;

  // Remainder shifted left with the next dividend bit; one extra bit since
  // rem_q < divisor means the shifted value is below 2 * divisor.
  logic [D_W:0]   rem_shift;
  logic           take;
  logic [D_W-1:0] rem_sub;

  always_comb begin
    rem_shift = {rem_q, dvd_q[N_W-1]};
    take      = (rem_shift >= {1'b0, divisor});
    // Difference is below divisor whenever it is used, so D_W bits suffice.
    rem_sub   = rem_shift[D_W-1:0] - divisor;
  end

  assign last = busy && (cnt_q == '0);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is synchronous; the whole datapath is cleared so an
      // aborted division leaves no stale quotient behind.
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      dvd_q    <= dividend;
      rem_q    <= '0;
      cnt_q    <= CNT_W'(ITER - 1);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (step && busy) begin
      dvd_q    <= dvd_q << 1;
      rem_q    <= take ? rem_sub : rem_shift[D_W-1:0];
      quotient <= {quotient[N_W-2:0], take};
      if (cnt_q == '0) begin
        busy <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit64_divide_0dot9999.sv
// Inverse of the 0.9999 leak: y = x * COEF_NUM / COEF_DEN on signed
// operands, truncated toward zero and saturated to the DATA_W range.
// Sign and magnitude are split here, the magnitude is scaled by COEF_NUM,
// divided serially by COEF_DEN, then sign and saturation are re-applied.
// Fixed latency: out_valid first rises 81 edges after the accept edge.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset; aborts any operation
//   in_valid   in_data valid
//   in_ready   high only while idle
//   in_data    signed operand x (sampled on accept only)
//   out_valid  high only while a result is held
//   out_ready  consumer accepts the result
//   out_data   signed result y
//   out_sat    result was clamped to the DATA_W range
module bit64_divide_0dot9999
  import leak_coef_pkg::*;
#(
  parameter int DATA_W   = LEAK_DATA_W,
  parameter int COEF_NUM = LEAK_COEF_NUM,
  parameter int COEF_DEN = LEAK_COEF_DEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int DEN_W = $clog2(COEF_DEN + 1);

  // Largest positive magnitude and largest negative magnitude representable.
  localparam logic [DIVIDEND_W-1:0] POS_LIM =
    (DIVIDEND_W'(1) << (DATA_W - 1)) - DIVIDEND_W'(1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM =
    DIVIDEND_W'(1) << (DATA_W - 1);

  leak_state_e state_q, state_d;

  logic                  accept;
  logic                  div_step;
  logic                  div_busy;
  logic                  div_last;
  logic                  sign_q;
  logic [DATA_W-1:0]     mag;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DATA_W-1:0]     res_d;
  logic                  sat_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign div_step  = (state_q == DIV) && div_busy;

  // Two's-complement negation taken as unsigned, so -2^(DATA_W-1) maps to
  // the magnitude 2^(DATA_W-1) without overflowing.
  assign mag      = in_data[DATA_W-1] ? -in_data : in_data;
  assign dividend = DIVIDEND_W'(mag) * DIVIDEND_W'(COEF_NUM);

  udiv_serial #(
    .N_W  (DIVIDEND_W),
    .D_W  (DEN_W),
    .ITER (ITER_N)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .step     (div_step),
    .dividend (dividend),
    .divisor  (DEN_W'(COEF_DEN)),
    .busy     (div_busy),
    .last     (div_last),
    .quotient (quotient)
  );

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)    state_d = DIV;
      DIV:  if (div_last)  state_d = FIN;
      FIN:                 state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Magnitude quotient is truncated; negating afterwards gives truncation
  // toward zero. A negative magnitude of exactly 2^(DATA_W-1) is legal.
  always_comb begin
    sat_d = 1'b0;
    res_d = quotient[DATA_W-1:0];
    if (!sign_q) begin
      if (quotient > POS_LIM) begin
        sat_d = 1'b1;
        res_d = POS_LIM[DATA_W-1:0];
      end
    end else begin
      if (quotient > NEG_LIM) begin
        sat_d = 1'b1;
        res_d = NEG_LIM[DATA_W-1:0];
      end else begin
        res_d = -quotient[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sign_q <= in_data[DATA_W-1];
      end
      // Result registers only change in FIN, so they hold through DONE.
      if (state_q == FIN) begin
        out_data <= res_d;
        out_sat  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_bit64_divide_0dot9999.sv
// Directed self-checking bench for bit64_divide_0dot9999, plus a round trip
// through a behavioural model of the forward 0.9999 block.
module tb_bit64_divide_0dot9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_sat;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bit64_divide_0dot9999 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  // Starts and ends just after a falling edge. Returns the result and the
  // number of rising edges from accept to the first out_valid.
  task automatic do_op(input logic [63:0] x, input bit release_out,
                       output logic [63:0] y, output logic sat,
                       output int lat);
    int waitc;
    waitc = 0;
    lat   = 0;
    y     = '0;
    sat   = 1'b0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      tests++; failed++;
      $display("FAIL op_in_ready_timeout x=%0d: in_ready=%b required 1", $signed(x), in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      tests++; failed++;
      $display("FAIL op_out_valid_timeout x=%0d: no out_valid within %0d edges", $signed(x), lat);
      return;
    end
    y   = out_data;
    sat = out_sat;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests++;
    if (out_data !== 64'd0) begin
      failed++; $display("FAIL reset_out_data: got %0d want 0", $signed(out_data));
    end
    tests++;
    if (out_sat !== 1'b0) begin
      failed++; $display("FAIL reset_out_sat: got %b want 0", out_sat);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] y;
    logic        sat;
    int          lat;
    do_op(64'd9999, 1'b1, y, sat, lat);
    tests++;
    if (y !== 64'd10000) begin
      failed++; $display("FAIL basic_data: got %0d want 10000", $signed(y));
    end
    tests++;
    if (sat !== 1'b0) begin
      failed++; $display("FAIL basic_sat: got %b want 0", sat);
    end
    tests++;
    if (lat !== 81) begin
      failed++; $display("FAIL basic_latency: got %0d want 81", lat);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] xs [7];
    logic [63:0] ys [7];
    logic        ss [7];
    logic [63:0] y;
    logic        sat;
    int          lat;
    xs[0] = 64'd123456789;          ys[0] = 64'd123469135;          ss[0] = 1'b0;
    xs[1] = -64'sd9999;             ys[1] = -64'sd10000;            ss[1] = 1'b0;
    xs[2] = 64'd1;                  ys[2] = 64'd1;                  ss[2] = 1'b0;
    xs[3] = -64'sd1;                ys[3] = -64'sd1;                ss[3] = 1'b0;
    xs[4] = 64'd0;                  ys[4] = 64'd0;                  ss[4] = 1'b0;
    xs[5] = 64'h7FFF_FFFF_FFFF_FFFF; ys[5] = 64'h7FFF_FFFF_FFFF_FFFF; ss[5] = 1'b1;
    xs[6] = 64'h8000_0000_0000_0000; ys[6] = 64'h8000_0000_0000_0000; ss[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(xs[i], 1'b1, y, sat, lat);
      tests++;
      if (y !== ys[i]) begin
        failed++;
        $display("FAIL vec%0d_data x=%0d: got %0d want %0d", i, $signed(xs[i]), $signed(y), $signed(ys[i]));
      end
      tests++;
      if (sat !== ss[i]) begin
        failed++; $display("FAIL vec%0d_sat x=%0d: got %b want %b", i, $signed(xs[i]), sat, ss[i]);
      end
      tests++;
      if (lat !== 81) begin
        failed++; $display("FAIL vec%0d_latency: got %0d want 81", i, lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] y;
    logic        sat;
    int          lat;
    do_op(64'd19998, 1'b0, y, sat, lat);
    tests++;
    if (y !== 64'd20000) begin
      failed++; $display("FAIL hold_data: got %0d want 20000", $signed(y));
    end
    // Stall the consumer while offering a new operand that must be ignored.
    in_valid = 1'b1;
    in_data  = 64'd5;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 64'd20000}) begin
        failed++;
        $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b out_data=%0d want 1 0 20000",
                 c, out_valid, in_ready, $signed(out_data));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failed++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    do_op(64'd1, 1'b1, y, sat, lat);
    tests++;
    if (y !== 64'd1) begin
      failed++; $display("FAIL hold_next_op: got %0d want 1", $signed(y));
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    in_valid = 1'b1;
    in_data  = 64'd9999;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, out_sat, out_data} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      failed++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b out_sat=%b out_data=%0d want 1 0 0 0",
               in_ready, out_valid, out_sat, $signed(out_data));
    end
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      failed++; $display("FAIL abort_spurious: out_valid high %0d cycles want 0", seen);
    end
  endtask

  // Forward block model: f = trunc(x * 9999 / 10000); the inverse must
  // recover x to within one LSB.
  task automatic test_round_trip();
    logic [63:0]        r;
    logic signed [63:0] x;
    logic signed [127:0] xw, fw, yw, d;
    logic [63:0]        y;
    logic               sat;
    int                 lat;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      x = $signed(r) >>> 2;
      if (x == -64'sh4000_0000_0000_0000) x = '0;
      xw = x;
      fw = (xw * 128'sd9999) / 128'sd10000;
      do_op(fw[63:0], 1'b1, y, sat, lat);
      yw = $signed(y);
      d  = yw - xw;
      tests++;
      if (d > 128'sd1 || d < -128'sd1 || sat !== 1'b0) begin
        failed++;
        $display("FAIL round_trip%0d x=%0d f=%0d: got y=%0d sat=%b want |y-x|<=1 sat=0",
                 i, x, $signed(fw[63:0]), $signed(y), sat);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_hold();
    test_abort();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
